// File: rtl/cpu_seq.sv
// Microcoded control sequencer for the 8-bit bus CPU.
// Fetch in T0-T1, opcode-driven execute in T2-T4, sole owner of bus strobes.
module cpu_seq #(
    parameter int EARLY_END = 1,
    parameter int NSTEPS    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       flag_c,
    input  logic       flag_z,
    output logic       pc_out,
    output logic       pc_en,
    output logic       pc_jmp,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ram_in,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flag_in,
    output logic       out_in,
    output logic       halted,
    output logic [2:0] step
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'he;
    localparam logic [3:0] OP_HLT = 4'hf;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam logic [2:0] T_LAST = 3'(NSTEPS - 1);

    logic       active;
    logic       halt_now;
    logic [2:0] last_step;
    logic [2:0] step_nxt;

    assign active   = run & ~halted;
    assign halt_now = (step == T2) && (opcode == OP_HLT);

    always_comb begin
        last_step = T2;
        unique case (opcode)
            OP_LDA, OP_STA: last_step = T3;
            OP_ADD, OP_SUB: last_step = T4;
            default:        last_step = T2;
        endcase
    end

    // last_step is never below T2, so fetch steps never end early
    always_comb begin
        step_nxt = step + 3'd1;
        if (EARLY_END != 0 && step == last_step)
            step_nxt = T0;
        else if (step >= T_LAST)
            step_nxt = T0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step   <= T0;
            halted <= 1'b0;
        end else if (active) begin
            if (halt_now)
                halted <= 1'b1;
            else
                step <= step_nxt;
        end
    end

    always_comb begin
        pc_out  = 1'b0;
        pc_en   = 1'b0;
        pc_jmp  = 1'b0;
        mar_in  = 1'b0;
        ram_out = 1'b0;
        ram_in  = 1'b0;
        ir_in   = 1'b0;
        ir_out  = 1'b0;
        a_in    = 1'b0;
        a_out   = 1'b0;
        b_in    = 1'b0;
        alu_out = 1'b0;
        alu_sub = 1'b0;
        flag_in = 1'b0;
        out_in  = 1'b0;
        if (active) begin
            unique case (step)
                T0: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                T1: begin
                    ram_out = 1'b1;
                    ir_in   = 1'b1;
                    pc_en   = 1'b1;
                end
                T2: begin
                    unique case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_out = 1'b1;
                            mar_in = 1'b1;
                        end
                        OP_LDI: begin
                            ir_out = 1'b1;
                            a_in   = 1'b1;
                        end
                        OP_JMP: begin
                            ir_out = 1'b1;
                            pc_jmp = 1'b1;
                        end
                        OP_JC: begin
                            ir_out = flag_c;
                            pc_jmp = flag_c;
                        end
                        OP_JZ: begin
                            ir_out = flag_z;
                            pc_jmp = flag_z;
                        end
                        OP_OUT: begin
                            a_out  = 1'b1;
                            out_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    unique case (opcode)
                        OP_LDA: begin
                            ram_out = 1'b1;
                            a_in    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out = 1'b1;
                            b_in    = 1'b1;
                            alu_sub = (opcode == OP_SUB);
                        end
                        OP_STA: begin
                            a_out  = 1'b1;
                            ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_out = 1'b1;
                        a_in    = 1'b1;
                        flag_in = 1'b1;
                        alu_sub = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    logic unused_nop;
    assign unused_nop = (opcode == OP_NOP);

endmodule

// File: tb/tb_cpu_seq.sv
// Directed bench for cpu_seq: early-end and full-wrap instances,
// microcode per opcode, stall, halt, reset and bus-ownership invariants.
module tb_cpu_seq;

    localparam logic [14:0] S_PC_OUT  = 15'h4000;
    localparam logic [14:0] S_PC_EN   = 15'h2000;
    localparam logic [14:0] S_PC_JMP  = 15'h1000;
    localparam logic [14:0] S_MAR_IN  = 15'h0800;
    localparam logic [14:0] S_RAM_OUT = 15'h0400;
    localparam logic [14:0] S_RAM_IN  = 15'h0200;
    localparam logic [14:0] S_IR_IN   = 15'h0100;
    localparam logic [14:0] S_IR_OUT  = 15'h0080;
    localparam logic [14:0] S_A_IN    = 15'h0040;
    localparam logic [14:0] S_A_OUT   = 15'h0020;
    localparam logic [14:0] S_B_IN    = 15'h0010;
    localparam logic [14:0] S_ALU_OUT = 15'h0008;
    localparam logic [14:0] S_ALU_SUB = 15'h0004;
    localparam logic [14:0] S_FLAG_IN = 15'h0002;
    localparam logic [14:0] S_OUT_IN  = 15'h0001;
    localparam logic [14:0] S_NONE    = 15'h0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst_n, run, flag_c, flag_z;
    logic [3:0] opcode;
    logic       pc_out, pc_en, pc_jmp, mar_in, ram_out, ram_in, ir_in;
    logic       ir_out, a_in, a_out, b_in, alu_out, alu_sub, flag_in;
    logic       out_in, halted;
    logic [2:0] step;

    logic       rst_w_n, run_w;
    logic [3:0] opcode_w;
    logic       w_pc_out, w_pc_en, w_pc_jmp, w_mar_in, w_ram_out;
    logic       w_ram_in, w_ir_in, w_ir_out, w_a_in, w_a_out, w_b_in;
    logic       w_alu_out, w_alu_sub, w_flag_in, w_out_in, w_halted;
    logic [2:0] w_step;

    cpu_seq #(.EARLY_END(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .flag_c(flag_c), .flag_z(flag_z),
        .pc_out(pc_out), .pc_en(pc_en), .pc_jmp(pc_jmp),
        .mar_in(mar_in), .ram_out(ram_out), .ram_in(ram_in),
        .ir_in(ir_in), .ir_out(ir_out), .a_in(a_in), .a_out(a_out),
        .b_in(b_in), .alu_out(alu_out), .alu_sub(alu_sub),
        .flag_in(flag_in), .out_in(out_in), .halted(halted),
        .step(step)
    );

    cpu_seq #(.EARLY_END(0)) u_wrap (
        .clk(clk), .rst_n(rst_w_n), .run(run_w), .opcode(opcode_w),
        .flag_c(flag_c), .flag_z(flag_z),
        .pc_out(w_pc_out), .pc_en(w_pc_en), .pc_jmp(w_pc_jmp),
        .mar_in(w_mar_in), .ram_out(w_ram_out), .ram_in(w_ram_in),
        .ir_in(w_ir_in), .ir_out(w_ir_out), .a_in(w_a_in),
        .a_out(w_a_out), .b_in(w_b_in), .alu_out(w_alu_out),
        .alu_sub(w_alu_sub), .flag_in(w_flag_in), .out_in(w_out_in),
        .halted(w_halted), .step(w_step)
    );

    logic [14:0] strobes, w_strobes;
    assign strobes = {pc_out, pc_en, pc_jmp, mar_in, ram_out, ram_in,
                      ir_in, ir_out, a_in, a_out, b_in, alu_out,
                      alu_sub, flag_in, out_in};
    assign w_strobes = {w_pc_out, w_pc_en, w_pc_jmp, w_mar_in,
                        w_ram_out, w_ram_in, w_ir_in, w_ir_out, w_a_in,
                        w_a_out, w_b_in, w_alu_out, w_alu_sub,
                        w_flag_in, w_out_in};

    // bus ownership invariants on both instances every cycle
    always @(negedge clk) begin
        checks++;
        assert ($onehot0({pc_out, ram_out, ir_out, a_out, alu_out})
                && !(pc_en && pc_jmp)
                && $onehot0({w_pc_out, w_ram_out, w_ir_out, w_a_out,
                             w_alu_out})
                && !(w_pc_en && w_pc_jmp))
        else begin
            errors++;
            $error("FAIL bus_inv got %h/%h", strobes, w_strobes);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [2:0] es,
                       input logic [14:0] ev, input logic eh);
        checks++;
        assert (step === es) else begin
            errors++;
            $error("FAIL %s step got %0d exp %0d", tag, step, es);
        end
        checks++;
        assert (strobes === ev) else begin
            errors++;
            $error("FAIL %s strobes got %h exp %h", tag, strobes, ev);
        end
        checks++;
        assert (halted === eh) else begin
            errors++;
            $error("FAIL %s halted got %b exp %b", tag, halted, eh);
        end
    endtask

    task automatic chk_w(input string tag, input logic [2:0] es,
                         input logic [14:0] ev);
        checks++;
        assert (w_step === es && w_strobes === ev) else begin
            errors++;
            $error("FAIL %s step/strobes got %0d/%h exp %0d/%h",
                   tag, w_step, w_strobes, es, ev);
        end
    endtask

    task automatic fetch(input string tag);
        chk({tag, "_t0"}, 3'd0, S_PC_OUT | S_MAR_IN, 1'b0);
        tick();
        chk({tag, "_t1"}, 3'd1, S_RAM_OUT | S_IR_IN | S_PC_EN, 1'b0);
        tick();
    endtask

    task automatic one_step(input string tag, input logic [3:0] op,
                            input logic [14:0] ev);
        opcode = op;
        fetch(tag);
        chk({tag, "_t2"}, 3'd2, ev, 1'b0);
        tick();
        chk({tag, "_end"}, 3'd0, S_PC_OUT | S_MAR_IN, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b1; opcode = 4'h0;
        flag_c = 1'b0; flag_z = 1'b0;
        rst_w_n = 1'b0; run_w = 1'b1; opcode_w = 4'h5;
        tick();
        tick();
        checks++;
        assert (step === 3'd0 && halted === 1'b0) else begin
            errors++;
            $error("FAIL reset step/halted got %0d/%b exp 0/0",
                   step, halted);
        end
        rst_n = 1'b1;

        // NOP: 0,1,2,0
        fetch("nop");
        chk("nop_t2", 3'd2, S_NONE, 1'b0);
        tick();

        // SUB
        opcode = 4'h3;
        fetch("sub");
        chk("sub_t2", 3'd2, S_IR_OUT | S_MAR_IN, 1'b0);
        tick();
        chk("sub_t3", 3'd3, S_RAM_OUT | S_B_IN | S_ALU_SUB, 1'b0);
        tick();
        chk("sub_t4", 3'd4,
            S_ALU_OUT | S_A_IN | S_FLAG_IN | S_ALU_SUB, 1'b0);
        tick();

        // ADD
        opcode = 4'h2;
        fetch("add");
        chk("add_t2", 3'd2, S_IR_OUT | S_MAR_IN, 1'b0);
        tick();
        chk("add_t3", 3'd3, S_RAM_OUT | S_B_IN, 1'b0);
        tick();
        chk("add_t4", 3'd4, S_ALU_OUT | S_A_IN | S_FLAG_IN, 1'b0);
        tick();

        // conditional jumps
        flag_c = 1'b1;
        one_step("jc1", 4'h7, S_IR_OUT | S_PC_JMP);
        flag_c = 1'b0;
        one_step("jc0", 4'h7, S_NONE);
        flag_z = 1'b1;
        one_step("jz1", 4'h8, S_IR_OUT | S_PC_JMP);
        flag_z = 1'b0;
        one_step("jz0", 4'h8, S_NONE);

        one_step("ldi", 4'h5, S_IR_OUT | S_A_IN);
        one_step("jmp", 4'h6, S_IR_OUT | S_PC_JMP);
        one_step("out", 4'he, S_A_OUT | S_OUT_IN);
        one_step("undef", 4'ha, S_NONE);

        // STA
        opcode = 4'h4;
        fetch("sta");
        chk("sta_t2", 3'd2, S_IR_OUT | S_MAR_IN, 1'b0);
        tick();
        chk("sta_t3", 3'd3, S_A_OUT | S_RAM_IN, 1'b0);
        tick();

        // LDA with 3-cycle stall in T3
        opcode = 4'h1;
        fetch("lda");
        chk("lda_t2", 3'd2, S_IR_OUT | S_MAR_IN, 1'b0);
        tick();
        run = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("lda_stall", 3'd3, S_NONE, 1'b0);
            tick();
        end
        chk("lda_stall_end", 3'd3, S_NONE, 1'b0);
        run = 1'b1;
        #1;
        chk("lda_t3", 3'd3, S_RAM_OUT | S_A_IN, 1'b0);
        tick();

        // HLT freezes step at T2
        opcode = 4'hf;
        fetch("hlt");
        chk("hlt_t2", 3'd2, S_NONE, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("halted", 3'd2, S_NONE, 1'b1);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("hlt_reset", 3'd0, S_PC_OUT | S_MAR_IN, 1'b0);
        opcode = 4'h1;
        rst_n = 1'b1;
        tick();
        tick();
        chk("rst_lda_t2", 3'd2, S_IR_OUT | S_MAR_IN, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid", 3'd0, S_PC_OUT | S_MAR_IN, 1'b0);
        rst_n = 1'b1;
        #1;
        fetch("restart");

        // EARLY_END=0 with LDI: full T0..T4 then wrap
        rst_w_n = 1'b1;
        chk_w("w_t0", 3'd0, S_PC_OUT | S_MAR_IN);
        tick();
        chk_w("w_t1", 3'd1, S_RAM_OUT | S_IR_IN | S_PC_EN);
        tick();
        chk_w("w_t2", 3'd2, S_IR_OUT | S_A_IN);
        tick();
        chk_w("w_t3", 3'd3, S_NONE);
        tick();
        chk_w("w_t4", 3'd4, S_NONE);
        tick();
        chk_w("w_wrap", 3'd0, S_PC_OUT | S_MAR_IN);
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_seq.md
Name: cpu_seq

Overview:
- Microcoded control sequencer for the 8-bit bus CPU.
- Steps through fetch (T0–T1) and execute (T2–T4) for the 4-bit opcode held in the instruction register.
- Drives every load, enable and bus-output strobe, including the program counter's pc_out, pc_en and pc_jmp.
- Sole owner of the shared bus: guarantees at most one bus driver per cycle.

Parameters:
- EARLY_END, 1: 1 = return to T0 the cycle after an instruction's last active step; 0 = always run T0..T4 and then wrap.
- NSTEPS, 5: number of T-states; fixed at 5 and must not be overridden.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  1 = advance; 0 = stall (hold state, all strobes low)
- opcode  in  4  IR[7:4], valid from T2 onward
- flag_c  in  1  registered carry flag
- flag_z  in  1  registered zero flag
- pc_out  out  1  PC drives bus
- pc_en  out  1  PC increment
- pc_jmp  out  1  PC loads from bus
- mar_in  out  1  MAR load
- ram_out  out  1  RAM drives bus
- ram_in  out  1  RAM write
- ir_in  out  1  IR load
- ir_out  out  1  IR[3:0] drives bus
- a_in  out  1  A register load
- a_out  out  1  A drives bus
- b_in  out  1  B register load
- alu_out  out  1  ALU drives bus
- alu_sub  out  1  ALU subtract select
- flag_in  out  1  flag register load
- out_in  out  1  output register load
- halted  out  1  CPU halted
- step  out  3  current T-state (0..4), for debug and bench

Behaviour:
State and outputs:
- Registered state: step[2:0] and halted.
- All strobes are combinational from (step, opcode, flags, run, halted).
- Strobes are 0 whenever run=0 or halted=1.

Reset:
- Asynchronous; sets step=0 and halted=0.
- With run=1, the first cycle after reset release is a fetch T0.
- Reset mid-instruction abandons the instruction with no partial strobes.

Microcode (every strobe not listed is 0):
- T0: pc_out, mar_in.
- T1: ram_out, ir_in, pc_en.
- LDA (0x1): T2 ir_out, mar_in; T3 ram_out, a_in; last step T3.
- ADD (0x2): T2 ir_out, mar_in; T3 ram_out, b_in; T4 alu_out, a_in, flag_in; last step T4.
- SUB (0x3): as ADD, with alu_sub=1 in T3 and T4.
- STA (0x4): T2 ir_out, mar_in; T3 a_out, ram_in; last step T3.
- LDI (0x5): T2 ir_out, a_in; last step T2.
- JMP (0x6): T2 ir_out, pc_jmp; last step T2.
- JC (0x7): T2 ir_out and pc_jmp, only if flag_c=1, otherwise no strobes; last step T2.
- JZ (0x8): as JC, gated by flag_z.
- OUT (0xE): T2 a_out, out_in; last step T2.
- HLT (0xF): T2 no strobes; halted is set on the clock edge ending T2.
- NOP (0x0) and undefined opcodes (0x9–0xD): no strobes in T2–T4; last step T2.

Step advance (on a clk edge with run=1 and halted=0):
- EARLY_END=1: if step equals the opcode's last step, step goes to 0; otherwise step+1.
- EARLY_END=0: step+1, wrapping 4→0.
- During T0/T1, opcode is ignored for the end decision.

Halt and stall:
- Once halted=1, step freezes and the block stays idle until rst_n is asserted; run has no effect.
- run=0 holds step, so the same T-state re-executes when run returns to 1.
- A stalled cycle therefore produces no side effects.

Flag timing:
- Flags are sampled combinationally in T2.
- Flags updated by the previous instruction's T4 flag_in are visible.

Invariants (asserted in the bench):
- At most one of pc_out, ram_out, ir_out, a_out, alu_out is high per cycle.
- pc_en and pc_jmp are never high together.

Test Plan:
- Reset release with run=1, opcode=0x0, EARLY_END=1 -> step sequence 0,1,2,0; T0 shows pc_out=mar_in=1; T1 shows ram_out=ir_in=pc_en=1; T2 shows all strobes 0.
- opcode=0x3 (SUB) -> T2 ir_out+mar_in; T3 ram_out+b_in+alu_sub; T4 alu_out+a_in+flag_in+alu_sub; then step=0.
- opcode=0x7 with flag_c=1 -> T2 ir_out+pc_jmp; repeat with flag_c=0 -> T2 all strobes 0; both return to T0 next cycle.
- opcode=0x5 with EARLY_END=0 -> T2 ir_out+a_in; T3 and T4 idle; wrap to 0 after 5 cycles.
- run=0 held 3 cycles at T3 of LDA -> step stays 3 with all strobes 0; on run=1, ram_out+a_in fire once.
- opcode=0xF -> halted=1 after T2, step frozen for 20 cycles, no strobes; assert rst_n mid-LDA at T2 -> step=0, halted=0 immediately.
